grad_mag_dir: RTL and testbench
===============================

Name: grad_mag_dir

Overview:
- Streaming stage directly downstream of top_module_Gx_Gy.
- Consumes the packed 32-bit gradient word {Gy, Gx} (two signed 16-bit values) on AXI4-Stream.
- Produces, per pixel, a saturated L1 gradient magnitude and a 2-bit quantised gradient direction, for the following non-maximum-suppression stage.
- Also checks line length, carries tuser/tlast through the pipeline, and fully honours tready backpressure.

Parameters:
- IMG_WIDTH, 800, pixels per line; used by the line-length checker.
- MAG_WIDTH, 12, magnitude output width; saturation ceiling is 2^MAG_WIDTH-1. Legal range 8..14.

Ports:
- i_clk  in  1  system clock.
- i_aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  32  [15:0] Gx signed, [31:16] Gy signed.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tuser  in  1  start of frame (first pixel).
- s_axis_tlast  in  1  end of line.
- s_axis_tready  out  1  stage can accept a beat.
- m_axis_tdata  out  16  [MAG_WIDTH-1:0] magnitude; [15:14] direction; remaining bits 0.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tuser  out  1  tuser delayed with its pixel.
- m_axis_tlast  out  1  tlast delayed with its pixel.
- m_axis_tready  in  1  downstream ready.
- o_line_err  out  1  one-cycle pulse on a line-length or tuser-position violation.

Behaviour:
- Reset: all outputs 0, all stage valid bits 0, column counter 0. Reset is async assert and sync release. Reset mid-frame drops all in-flight beats; after release the block is empty and ready.
- Pipeline: 3 register stages (S1, S2, S3); S3 drives the m_axis outputs.
- Global enable en = ~m_axis_tvalid | m_axis_tready. All stages advance only when en=1; s_axis_tready = en.
- A beat is accepted when s_axis_tvalid & s_axis_tready.
- Latency: exactly 3 cycles from acceptance to m_axis_tvalid, when tready is held high.
- Bubbles advance through the pipeline as invalid slots.
- When m_axis_tready=0 with m_axis_tvalid=1: every output holds stable and s_axis_tready=0. No beat is lost, duplicated or reordered.
- S1: ax=|Gx|, ay=|Gy| as 16-bit unsigned (|-32768|=32768). Register sx=Gx[15] and sy=Gy[15], plus tuser/tlast.
- S2:
  - sum = ax+ay, 17-bit.
  - a256 = ay<<8.
  - x106 = ax*106.
  - x618 = ax*618.
  - All products 27-bit unsigned, no truncation.
- S3 magnitude: min(sum, 2^MAG_WIDTH-1).
- S3 direction (the 106/256 and 618/256 constants approximate tan22.5° and tan67.5°):
  - a256 <= x106 -> 0 (0°).
  - else a256 >= x618 -> 2 (90°).
  - else sx==sy -> 1 (45°).
  - else 3 (135°).
  - Gx=Gy=0 gives magnitude 0, direction 0.
- Column checker, evaluated on each accepted beat (col = column counter):
  - tuser=1 and col!=0 -> error; col reloads to 1.
  - tlast=1 and col!=IMG_WIDTH-1 -> error; col set to 0.
  - tlast=0 and col==IMG_WIDTH-1 -> error; col wraps to 0.
  - Otherwise col increments.
  - Simultaneous tuser and tlast on one beat: both checks are evaluated, and a single error pulse is produced; the tlast rule sets col.
  - o_line_err asserts the cycle after acceptance. It is independent of output backpressure and never blocks data.

Test Plan:
- Gx=100, Gy=0 -> after 3 cycles tdata magnitude=100, direction=0; Gx=0, Gy=-50 -> magnitude=50, direction=2.
- Gx=30, Gy=30 -> magnitude=60, direction=1; Gx=-30, Gy=30 -> magnitude=60, direction=3; Gx=Gy=0 -> 0/0.
- Gx=4000, Gy=1000 -> magnitude=4095 (saturated), direction=0; Gx=-32768, Gy=-32768 -> magnitude=4095, direction=1.
- 8x4 frame (IMG_WIDTH=8) with random m_axis_tready at 50%:
  - output sequence equals the reference model;
  - tuser is on beat 0 only and tlast on every 8th beat;
  - s_axis_tready=0 whenever the output is stalled;
  - o_line_err never fires.
- IMG_WIDTH=8: tlast on column 5 -> o_line_err pulses once, next beat counted as column 0; tuser on column 3 -> one pulse.
- Assert i_aresetn low mid-line with 3 beats in flight -> m_axis_tvalid=0 immediately. After release, a new frame streams with correct data and no spurious o_line_err.

Source files
------------

// File: rtl/grad_mag_dir.sv
// Gradient magnitude / direction stage: saturated L1 magnitude plus a 2-bit
// quantised direction per pixel, with line-length checking and full backpressure.
module grad_mag_dir #(
   parameter int unsigned IMG_WIDTH = 800,
   parameter int unsigned MAG_WIDTH = 12
) (
   input  logic        i_clk,
   input  logic        i_aresetn,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tuser,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tuser,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        o_line_err
);

   localparam int unsigned COL_W  = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned SUM_W  = 17;
   localparam int unsigned PROD_W = 27;
   localparam int unsigned DATA_W = 16;
   localparam logic [SUM_W-1:0]  MAG_MAX  = SUM_W'((1 << MAG_WIDTH) - 1);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [PROD_W-1:0] K_LO     = PROD_W'(106);
   localparam logic [PROD_W-1:0] K_HI     = PROD_W'(618);

   typedef struct packed {
      logic [15:0] ax;
      logic [15:0] ay;
      logic        sx;
      logic        sy;
      logic        user;
      logic        last;
   } s1_t;

   typedef struct packed {
      logic [SUM_W-1:0]  sum;
      logic [PROD_W-1:0] a256;
      logic [PROD_W-1:0] x106;
      logic [PROD_W-1:0] x618;
      logic              sx;
      logic              sy;
      logic              user;
      logic              last;
   } s2_t;

   logic [1:0]        rst_sync_q, rst_sync_d;
   logic              rst_n;
   logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   s1_t               s1_q, s1_d;
   s2_t               s2_q, s2_d;
   logic [DATA_W-1:0] data3_q, data3_d;
   logic              user3_q, user3_d, last3_q, last3_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              err_q, err_d;

   logic              en_c, acc_c;
   logic [15:0]       gx_c, gy_c;
   logic [1:0]        dir_c;
   logic [MAG_WIDTH-1:0] mag_c;

   // Reset release is re-timed to the clock; assertion stays asynchronous.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) rst_sync_q <= '0;
      else            rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   always_comb begin
      en_c    = ~v3_q | m_axis_tready;
      acc_c   = s_axis_tvalid & en_c & rst_n;
      gx_c    = s_axis_tdata[15:0];
      gy_c    = s_axis_tdata[31:16];

      v1_d    = v1_q;
      s1_d    = s1_q;
      v2_d    = v2_q;
      s2_d    = s2_q;
      v3_d    = v3_q;
      data3_d = data3_q;
      user3_d = user3_q;
      last3_d = last3_q;
      col_d   = col_q;
      err_d   = 1'b0;

      // Thresholds compare ay*256 against ax*tan(22.5)*256 and ax*tan(67.5)*256.
      mag_c = (s2_q.sum >= MAG_MAX) ? MAG_MAX[MAG_WIDTH-1:0] : s2_q.sum[MAG_WIDTH-1:0];
      if (s2_q.a256 <= s2_q.x106)      dir_c = 2'd0;
      else if (s2_q.a256 >= s2_q.x618) dir_c = 2'd2;
      else if (s2_q.sx == s2_q.sy)     dir_c = 2'd1;
      else                             dir_c = 2'd3;

      if (en_c) begin
         v1_d      = acc_c;
         s1_d.ax   = gx_c[15] ? 16'(~gx_c + 16'd1) : gx_c;
         s1_d.ay   = gy_c[15] ? 16'(~gy_c + 16'd1) : gy_c;
         s1_d.sx   = gx_c[15];
         s1_d.sy   = gy_c[15];
         s1_d.user = s_axis_tuser;
         s1_d.last = s_axis_tlast;

         v2_d      = v1_q;
         s2_d.sum  = SUM_W'(s1_q.ax) + SUM_W'(s1_q.ay);
         s2_d.a256 = PROD_W'(s1_q.ay) << 8;
         s2_d.x106 = PROD_W'(s1_q.ax) * K_LO;
         s2_d.x618 = PROD_W'(s1_q.ax) * K_HI;
         s2_d.sx   = s1_q.sx;
         s2_d.sy   = s1_q.sy;
         s2_d.user = s1_q.user;
         s2_d.last = s1_q.last;

         v3_d      = v2_q;
         data3_d   = {dir_c, 14'(mag_c)};
         user3_d   = s2_q.user;
         last3_d   = s2_q.last;
      end

      // Column checker; a tuser+tlast beat yields one pulse and tlast decides col.
      if (acc_c) begin
         err_d = (s_axis_tuser && (col_q != '0)) ||
                 (s_axis_tlast && (col_q != COL_LAST)) ||
                 (!s_axis_tlast && (col_q == COL_LAST));
         if (s_axis_tlast)           col_d = '0;
         else if (s_axis_tuser)      col_d = COL_W'(1);
         else if (col_q == COL_LAST) col_d = '0;
         else                        col_d = col_q + COL_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         s1_q    <= '0;
         v2_q    <= 1'b0;
         s2_q    <= '0;
         v3_q    <= 1'b0;
         data3_q <= '0;
         user3_q <= 1'b0;
         last3_q <= 1'b0;
         col_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         s1_q    <= s1_d;
         v2_q    <= v2_d;
         s2_q    <= s2_d;
         v3_q    <= v3_d;
         data3_q <= data3_d;
         user3_q <= user3_d;
         last3_q <= last3_d;
         col_q   <= col_d;
         err_q   <= err_d;
      end
   end

   assign s_axis_tready = en_c & rst_n;
   assign m_axis_tdata  = data3_q;
   assign m_axis_tvalid = v3_q;
   assign m_axis_tuser  = user3_q;
   assign m_axis_tlast  = last3_q;
   assign o_line_err    = err_q;

endmodule

// File: tb/tb_grad_mag_dir.sv
// Scoreboard bench for grad_mag_dir: driver pushes reference results, monitors
// pop and compare outputs, line-error pulses, stall behaviour and latency.
module tb_grad_mag_dir;

   localparam int unsigned IMG_W = 8;
   localparam int unsigned MAG_W = 12;

   logic        clk = 1'b0;
   logic        i_aresetn;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
   logic        o_line_err;

   always #5 clk = ~clk;

   grad_mag_dir #(.IMG_WIDTH(IMG_W), .MAG_WIDTH(MAG_W)) dut (
      .i_clk         (clk),
      .i_aresetn     (i_aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .o_line_err    (o_line_err)
   );

   typedef struct {
      logic [15:0] data;
      logic        user;
      logic        last;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   err_pulses = 0;
   int   model_col = 0;
   bit   rnd_ready = 1'b0;
   bit   err_now = 1'b0;
   bit   err_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: L1 magnitude clipped to the ceiling, direction from tan thresholds.
   function automatic logic [15:0] ref_word(input int gx, input int gy);
      int ax, ay, mag, dir, ceil_v;
      ax     = (gx < 0) ? -gx : gx;
      ay     = (gy < 0) ? -gy : gy;
      ceil_v = (1 << MAG_W) - 1;
      mag    = (ax + ay > ceil_v) ? ceil_v : ax + ay;
      if (ay * 256 <= ax * 106)      dir = 0;
      else if (ay * 256 >= ax * 618) dir = 2;
      else if ((gx < 0) == (gy < 0)) dir = 1;
      else                           dir = 3;
      return 16'((dir << 14) + mag);
   endfunction

   // Position tracker for the line: returns whether this beat breaks framing.
   function automatic bit ref_col(input bit u, input bit l);
      bit at_end, e;
      at_end = (model_col == IMG_W - 1);
      e = (u && model_col != 0) || (l != at_end);
      if (l || at_end) model_col = 0;
      else if (u)      model_col = 1;
      else             model_col = model_col + 1;
      if (l && !at_end && u) model_col = 0;
      return e;
   endfunction

   task automatic send(input int gx, input int gy, input bit u, input bit l);
      int guard = 0;
      bit done = 1'b0;
      s_axis_tdata  = {16'(gy), 16'(gx)};
      s_axis_tvalid = 1'b1;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      while (!done) begin
         m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #3;
         if (s_axis_tready) begin
            exp_t e;
            e.data = ref_word(gx, gy);
            e.user = u;
            e.last = l;
            e.cyc  = cyc;
            e.lat  = !rnd_ready;
            sb.push_back(e);
            err_now = ref_col(u, l);
            done = 1'b1;
         end else if (++guard > 200) begin
            chk("accept_timeout", 32'(guard), 0);
            done = 1'b1;
         end
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 500) begin
         idle(1);
         g++;
      end
      chk("drain_left", 32'(sb.size()), 0);
      idle(2);
   endtask

   function automatic int rnd_g();
      if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom())));
      return int'($urandom_range(0, 400)) - 200;
   endfunction

   // Output scoreboard and stall behaviour
   logic [15:0] pd;
   logic        pu, pl;
   bit          pstall = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      #4;
      if (pstall) begin
         chk("hold_valid", 32'(m_axis_tvalid), 1);
         chk("hold_data", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'({pd, pu, pl}));
      end
      if (m_axis_tvalid && !m_axis_tready) chk("stall_s_ready", 32'(s_axis_tready), 0);
      if (m_axis_tvalid && m_axis_tready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h with empty scoreboard", m_axis_tdata);
         end else begin
            e = sb.pop_front();
            chk("tdata", 32'(m_axis_tdata), 32'(e.data));
            chk("tuser", 32'(m_axis_tuser), 32'(e.user));
            chk("tlast", 32'(m_axis_tlast), 32'(e.last));
            if (e.lat) chk("latency", 32'(cyc - e.cyc), 3);
         end
      end
      pstall = m_axis_tvalid && !m_axis_tready && i_aresetn;
      pd = m_axis_tdata;
      pu = m_axis_tuser;
      pl = m_axis_tlast;
   end

   // Line-error pulse must follow the offending acceptance by one cycle
   always @(negedge clk) begin
      #4;
      chk("line_err", 32'(o_line_err), 32'(err_prev));
      if (o_line_err) err_pulses++;
      err_prev = err_now;
      err_now  = 1'b0;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      i_aresetn     = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_tdata", 32'(m_axis_tdata), 0);
      chk("rst_tuser_tlast", 32'({m_axis_tuser, m_axis_tlast}), 0);
      chk("rst_line_err", 32'(o_line_err), 0);
      chk("rst_s_ready", 32'(s_axis_tready), 0);
      @(negedge clk);
      i_aresetn = 1'b1;
      idle(4);

      // Directed line, tready held high so latency is exact
      rnd_ready = 1'b0;
      err_pulses = 0;
      send(100, 0, 1, 0);
      send(0, -50, 0, 0);
      send(30, 30, 0, 0);
      send(-30, 30, 0, 0);
      send(0, 0, 0, 0);
      send(4000, 1000, 0, 0);
      send(-32768, -32768, 0, 0);
      send(7, -3, 0, 1);
      drain();
      chk("directed_no_err", 32'(err_pulses), 0);

      // Random 8x4 frame with 50% downstream ready
      rnd_ready = 1'b1;
      err_pulses = 0;
      for (int ln = 0; ln < 4; ln++) begin
         for (int c = 0; c < int'(IMG_W); c++) begin
            send(rnd_g(), rnd_g(), (ln == 0 && c == 0), (c == int'(IMG_W) - 1));
            if ($urandom_range(0, 3) == 0) idle(1);
         end
      end
      drain();
      chk("frame_no_err", 32'(err_pulses), 0);

      // Early tlast on column 5, then a correct line
      err_pulses = 0;
      for (int c = 0; c < 6; c++) send(rnd_g(), rnd_g(), (c == 0), (c == 5));
      for (int c = 0; c < int'(IMG_W); c++) send(rnd_g(), rnd_g(), 1'b0, (c == int'(IMG_W) - 1));
      drain();
      chk("short_line_pulses", 32'(err_pulses), 1);

      // tuser on column 3 restarts the count
      err_pulses = 0;
      for (int c = 0; c < 3; c++) send(rnd_g(), rnd_g(), 1'b0, 1'b0);
      send(rnd_g(), rnd_g(), 1'b1, 1'b0);
      for (int c = 1; c < int'(IMG_W); c++) send(rnd_g(), rnd_g(), 1'b0, (c == int'(IMG_W) - 1));
      drain();
      chk("late_tuser_pulses", 32'(err_pulses), 1);

      // Reset with three beats in flight
      rnd_ready = 1'b0;
      err_pulses = 0;
      send(11, 22, 1, 0);
      send(-5, 9, 0, 0);
      send(300, -1, 0, 0);
      #1;
      chk("pre_rst_valid", 32'(m_axis_tvalid), 1);
      i_aresetn = 1'b0;
      sb.delete();
      err_now   = 1'b0;
      err_prev  = 1'b0;
      model_col = 0;
      #1;
      chk("mid_rst_valid", 32'(m_axis_tvalid), 0);
      chk("mid_rst_s_ready", 32'(s_axis_tready), 0);
      repeat (2) @(negedge clk);
      i_aresetn = 1'b1;
      idle(3);
      rnd_ready = 1'b1;
      for (int ln = 0; ln < 2; ln++) begin
         for (int c = 0; c < int'(IMG_W); c++)
            send(rnd_g(), rnd_g(), (ln == 0 && c == 0), (c == int'(IMG_W) - 1));
      end
      drain();
      chk("post_rst_no_err", 32'(err_pulses), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
